xtensa_reset_sequencer: RTL and testbench



---
 rtl/xtensa_reset_sequencer_if.sv | 29 ++
 rtl/xtensa_reset_sequencer.sv | 124 ++++++++++++
 tb/tb_xtensa_reset_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/xtensa_reset_sequencer_if.sv
// Purpose: per-core reset request/response bundle between the system and the
//          reset sequencer.
// Signals:
//   CoreResetReq  - per-core software reset request (level, rising edge = request)
//   BReset        - per-core active-high reset to the Xtensa wrappers
//   CoreResetAck  - one-cycle pulse when a software reset of a core completes
//   AllReleased   - high once the power-on sequence has released every core
interface xtensa_reset_sequencer_if #(
  parameter int unsigned NUM_CORES = 2
);
  logic [NUM_CORES-1:0] CoreResetReq;
  logic [NUM_CORES-1:0] BReset;
  logic [NUM_CORES-1:0] CoreResetAck;
  logic                 AllReleased;

  modport master (
    output CoreResetReq,
    input  BReset,
    input  CoreResetAck,
    input  AllReleased
  );

  modport slave (
    input  CoreResetReq,
    output BReset,
    output CoreResetAck,
    output AllReleased
  );
endinterface

// File: rtl/xtensa_reset_sequencer.sv
// Purpose: multi-core reset sequencer. Synchronises the system reset, holds all
//          cores in reset for HOLD_CYCLES, releases them one by one every
//          STAGGER_CYCLES, then serves per-core software reset pulses.
// Ports:
//   CLK      - single clock for all logic
//   BResetN  - system reset, asynchronous assert, active-low
//   bus      - slave side of xtensa_reset_sequencer_if (requests in, resets/acks out)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_HOLD    | all cores held, counting up to HOLD_CYCLES
// ST_STAGGER | core 0 released, remaining cores released one per stagger step
// ST_RUN     | every core released, software reset requests are served
module xtensa_reset_sequencer #(
  parameter int unsigned NUM_CORES       = 2,
  parameter int unsigned HOLD_CYCLES     = 101,
  parameter int unsigned STAGGER_CYCLES  = 16,
  parameter int unsigned SW_PULSE_CYCLES = 8,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                     CLK,
  input  logic                     BResetN,
  xtensa_reset_sequencer_if.slave  bus
);

  localparam int unsigned LAST_THR = HOLD_CYCLES + (NUM_CORES - 1) * STAGGER_CYCLES;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [NUM_CORES-1:0]   r_breset, w_breset_nxt;
  logic [NUM_CORES-1:0]   r_ack, w_ack_nxt;
  logic                   r_all, w_all_nxt;
  logic [NUM_CORES-1:0]   r_req_q, w_req_rise;
  logic [CNT_W-1:0]       r_soft_cnt [NUM_CORES];
  logic [CNT_W-1:0]       w_soft_nxt [NUM_CORES];

  // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_rst_sync = r_sync[SYNC_STAGES-1];

  // The synchronised reset doubles as the async clear of all sequencer state,
  // so a BResetN drop (even a glitch) returns the outputs to reset at once.
  always_ff @(posedge CLK or negedge w_rst_sync) begin
    if (!w_rst_sync) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_breset   <= '1;
      r_ack      <= '0;
      r_all      <= 1'b0;
      r_req_q    <= '0;
      r_soft_cnt <= '{default: '0};
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_breset   <= w_breset_nxt;
      r_ack      <= w_ack_nxt;
      r_all      <= w_all_nxt;
      r_req_q    <= bus.CoreResetReq;
      r_soft_cnt <= w_soft_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_breset_nxt = r_breset;
    w_ack_nxt    = '0;
    w_soft_nxt   = r_soft_cnt;
    w_req_rise   = bus.CoreResetReq & ~r_req_q;

    unique case (r_state)
      ST_HOLD, ST_STAGGER: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // A core leaves reset once the counter reaches its release point;
        // with STAGGER_CYCLES = 0 all points coincide.
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          if (32'(w_cnt_nxt) >= HOLD_CYCLES + i * STAGGER_CYCLES)
            w_breset_nxt[i] = 1'b0;
        end
        if (32'(w_cnt_nxt) >= LAST_THR)
          w_state_nxt = ST_RUN;
        else if (32'(w_cnt_nxt) >= HOLD_CYCLES)
          w_state_nxt = ST_STAGGER;
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          if (r_soft_cnt[i] != '0) begin
            // Busy cores ignore new request edges.
            w_soft_nxt[i] = r_soft_cnt[i] - CNT_W'(1);
            if (r_soft_cnt[i] == CNT_W'(1)) begin
              w_breset_nxt[i] = 1'b0;
              w_ack_nxt[i]    = 1'b1;
            end
          end else if (w_req_rise[i]) begin
            w_breset_nxt[i] = 1'b1;
            w_soft_nxt[i]   = CNT_W'(SW_PULSE_CYCLES);
          end
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase

    w_all_nxt = (w_state_nxt == ST_RUN);
  end

  assign bus.BReset       = r_breset;
  assign bus.CoreResetAck = r_ack;
  assign bus.AllReleased  = r_all;

endmodule

// File: tb/tb_xtensa_reset_sequencer.sv
// Purpose: directed self-checking bench for xtensa_reset_sequencer.
//          dut_a uses default parameters; dut_b has 4 cores and no stagger.
module tb_xtensa_reset_sequencer;

  logic CLK;
  logic BResetN;

  int n_checks = 0;
  int n_errors = 0;

  xtensa_reset_sequencer_if #(.NUM_CORES(2)) if_a ();
  xtensa_reset_sequencer_if #(.NUM_CORES(4)) if_b ();

  xtensa_reset_sequencer #(.NUM_CORES(2)) dut_a (
    .CLK     (CLK),
    .BResetN (BResetN),
    .bus     (if_a.slave)
  );

  xtensa_reset_sequencer #(.NUM_CORES(4), .STAGGER_CYCLES(0)) dut_b (
    .CLK     (CLK),
    .BResetN (BResetN),
    .bus     (if_b.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Release BResetN and follow the power-on sequence edge by edge.
  // Edge 2 lifts rst_sync, edge 103 releases core 0, edge 119 core 1.
  // Request toggles during HOLD must leave no trace.
  task automatic boot_check(input string pfx);
    int ack_seen;
    ack_seen = 0;
    BResetN = 1'b1;
    for (int n = 1; n <= 125; n++) begin
      tick();
      if (n == 40) if_a.CoreResetReq = 2'b01;
      if (n == 60) if_a.CoreResetReq = 2'b00;
      if (n == 80) if_a.CoreResetReq = 2'b11;
      if (n == 90) if_a.CoreResetReq = 2'b00;
      if (if_a.CoreResetAck != 2'b00) ack_seen++;
      if (n == 102) begin
        chk({pfx, "_a_e102"}, if_a.BReset, 2'b11);
        chk({pfx, "_b_e102"}, if_b.BReset, 4'hF);
        chk({pfx, "_b_all_e102"}, if_b.AllReleased, 1'b0);
      end
      if (n == 103) begin
        chk({pfx, "_a_e103"}, if_a.BReset, 2'b10);
        chk({pfx, "_b_e103"}, if_b.BReset, 4'h0);
        chk({pfx, "_b_all_e103"}, if_b.AllReleased, 1'b1);
      end
      if (n == 118) begin
        chk({pfx, "_a_e118"}, if_a.BReset, 2'b10);
        chk({pfx, "_a_all_e118"}, if_a.AllReleased, 1'b0);
      end
      if (n == 119) begin
        chk({pfx, "_a_e119"}, if_a.BReset, 2'b00);
        chk({pfx, "_a_all_e119"}, if_a.AllReleased, 1'b1);
      end
      if (n == 125) chk({pfx, "_a_e125"}, if_a.BReset, 2'b00);
    end
    chk({pfx, "_hold_acks"}, ack_seen, 0);
  endtask

  initial begin
    int a0, a1;
    BResetN = 1'b0;
    if_a.CoreResetReq = '0;
    if_b.CoreResetReq = '0;

    repeat (5) tick();
    chk("rst_breset_a", if_a.BReset, 2'b11);
    chk("rst_ack_a", if_a.CoreResetAck, 2'b00);
    chk("rst_all_a", if_a.AllReleased, 1'b0);
    chk("rst_breset_b", if_b.BReset, 4'hF);

    boot_check("boot1");

    // Single software reset on core 1: 8 edges high, ack on the falling edge.
    if_a.CoreResetReq = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("sw1_start", if_a.BReset, 2'b10);
      if (k == 8) begin
        chk("sw1_k8", if_a.BReset, 2'b10);
        chk("sw1_ack_k8", if_a.CoreResetAck, 2'b00);
      end
      if (k == 9) begin
        chk("sw1_end", if_a.BReset, 2'b00);
        chk("sw1_ack", if_a.CoreResetAck, 2'b10);
        chk("sw1_all", if_a.AllReleased, 1'b1);
      end
      if (k == 10) chk("sw1_ack_gone", if_a.CoreResetAck, 2'b00);
    end
    if_a.CoreResetReq = 2'b00;
    tick();

    // Both cores together; a mid-pulse re-toggle on core 0 is ignored.
    a0 = 0;
    a1 = 0;
    if_a.CoreResetReq = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) if_a.CoreResetReq = 2'b10;
      if (k == 4) if_a.CoreResetReq = 2'b11;
      if (if_a.CoreResetAck[0]) a0++;
      if (if_a.CoreResetAck[1]) a1++;
      if (k == 1) chk("sw2_start", if_a.BReset, 2'b11);
      if (k == 8) chk("sw2_k8", if_a.BReset, 2'b11);
      if (k == 9) begin
        chk("sw2_end", if_a.BReset, 2'b00);
        chk("sw2_ack", if_a.CoreResetAck, 2'b11);
        chk("sw2_all", if_a.AllReleased, 1'b1);
      end
      if (k == 15) chk("sw2_no_repulse", if_a.BReset, 2'b00);
    end
    chk("sw2_ack0_count", a0, 1);
    chk("sw2_ack1_count", a1, 1);

    // BResetN drop during a core-1 soft reset.
    if_a.CoreResetReq = 2'b00;
    tick();
    if_a.CoreResetReq = 2'b10;
    tick();
    chk("mid_pulse_started", if_a.BReset, 2'b10);
    tick();
    tick();
    BResetN = 1'b0;
    #1;
    chk("async_breset", if_a.BReset, 2'b11);
    chk("async_all", if_a.AllReleased, 1'b0);
    chk("async_ack", if_a.CoreResetAck, 2'b00);
    chk("async_breset_b", if_b.BReset, 4'hF);
    repeat (3) tick();
    if_a.CoreResetReq = 2'b00;
    boot_check("boot2");

    // Sub-cycle glitch on BResetN still resets and restarts the sequence.
    tick();
    #2 BResetN = 1'b0;
    #1 BResetN = 1'b1;
    #1;
    chk("glitch_breset", if_a.BReset, 2'b11);
    chk("glitch_all", if_a.AllReleased, 1'b0);
    repeat (3) tick();
    chk("glitch_hold", if_a.BReset, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
